// File: rtl/cell_bist_ctrl_if.sv
// Handshake and CUT-facing signal bundle for cell_bist_ctrl.
// master: SoC test controller / CUT side; slave: the BIST sequencer.
interface cell_bist_ctrl_if #(
  parameter int N_IN  = 3,
  parameter int CNT_W = 8
);
  logic              start;
  logic              abort;
  logic [N_IN-1:0]   dut_in;
  logic              dut_out;
  logic              busy;
  logic              done;
  logic              pass;
  logic [CNT_W-1:0]  err_cnt;
  logic              fail_valid;
  logic [N_IN-1:0]   fail_vec;

  modport master (
    output start, abort, dut_out,
    input  dut_in, busy, done, pass, err_cnt, fail_valid, fail_vec
  );

  modport slave (
    input  start, abort, dut_out,
    output dut_in, busy, done, pass, err_cnt, fail_valid, fail_vec
  );
endinterface

// File: rtl/cell_bist_ctrl.sv
// Exhaustive-vector BIST sequencer for one combinational standard cell.
// Optional macro CELL_BIST_SYNC_EN: 2-flop synchroniser on dut_out, +2 cycles per vector.
module cell_bist_ctrl #(
  parameter int                  N_IN   = 3,
  parameter logic [2**N_IN-1:0]  TRUTH  = 8'h1F,
  parameter int                  SETTLE = 4,
  parameter int                  CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  cell_bist_ctrl_if.slave    bus
);

`ifdef CELL_BIST_SYNC_EN
  localparam int PER = SETTLE + 2;
`else
  localparam int PER = SETTLE;
`endif
  localparam int              CTR_W  = (PER > 1) ? $clog2(PER) : 1;
  localparam logic [CTR_W-1:0] RELOAD = CTR_W'(PER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_IN-1:0]    dut_in_q, dut_in_d;
  logic [CTR_W-1:0]   ctr_q, ctr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               fail_valid_q, fail_valid_d;
  logic [N_IN-1:0]    fail_vec_q, fail_vec_d;
  logic               cut_bit;
  logic               mismatch;

`ifdef CELL_BIST_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.dut_out;
      sync2_q <= sync1_q;
    end
  end

  always_comb cut_bit = sync2_q;
`else
  always_comb cut_bit = bus.dut_out;
`endif

  always_comb mismatch = (cut_bit != TRUTH[dut_in_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dut_in_q     <= '0;
      ctr_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_cnt_q    <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
    end else begin
      state_q      <= state_d;
      dut_in_q     <= dut_in_d;
      ctr_q        <= ctr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_cnt_q    <= err_cnt_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    dut_in_d     = dut_in_q;
    ctr_d        = ctr_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    err_cnt_d    = err_cnt_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d      = RUN;
          dut_in_d     = '0;
          ctr_d        = RELOAD;
          busy_d       = 1'b1;
          pass_d       = 1'b0;
          err_cnt_d    = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
        end
      end

      RUN: begin
        // abort discards a coincident sample, so it is tested before the counter
        if (bus.abort) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          dut_in_d = '0;
          pass_d   = 1'b0;
        end else if (ctr_q == '0) begin
          if (mismatch) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              fail_vec_d   = dut_in_q;
            end
          end
          if (dut_in_q != '1) begin
            dut_in_d = dut_in_q + 1'b1;
            ctr_d    = RELOAD;
          end else begin
            state_d  = DONE;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            pass_d   = (err_cnt_d == '0);
            dut_in_d = '0;
          end
        end else begin
          ctr_d = ctr_q - 1'b1;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign bus.dut_in     = dut_in_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.fail_valid = fail_valid_q;
  assign bus.fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_cell_bist_ctrl.sv
// Self-checking bench for cell_bist_ctrl: table vectors, random CUT tables, corner sequences.
// Honours CELL_BIST_SYNC_EN for the per-vector period.
module tb_cell_bist_ctrl;

`ifdef CELL_BIST_SYNC_EN
  localparam int PER = 6;
`else
  localparam int PER = 4;
`endif
  localparam int NV    = 8;
  localparam int TOTAL = NV * PER;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] cut_tbl = 8'h1F;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cell_bist_ctrl_if #(.N_IN(3), .CNT_W(8)) bus ();
  cell_bist_ctrl_if #(.N_IN(3), .CNT_W(2)) bsat ();

  cell_bist_ctrl #(.N_IN(3), .TRUTH(8'h1F), .SETTLE(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  cell_bist_ctrl #(.N_IN(3), .TRUTH(8'h1F), .SETTLE(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(bsat)
  );

  always_comb bus.dut_out = cut_tbl[bus.dut_in];
  always_comb bsat.dut_out = 1'b0;

  typedef struct {
    logic [7:0] tbl;
    int         err;
    int         fv;
    int         fvec;
    int         ps;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // OAI21 golden value computed from the boolean equation
  function automatic logic gold(input int v);
    logic a, b, c;
    a = v[0]; b = v[1]; c = v[2];
    return ~((a | b) & c);
  endfunction

  function automatic void model(input logic [7:0] tbl, input int cmax,
                                output int err, output int fv, output int fvec, output int ps);
    err = 0; fv = 0; fvec = 0;
    for (int v = 0; v < NV; v++) begin
      if (tbl[v] != gold(v)) begin
        if (fv == 0) begin fv = 1; fvec = v; end
        if (err < cmax) err++;
      end
    end
    ps = (err == 0) ? 1 : 0;
  endfunction

  task automatic run(input logic [7:0] tbl, input bit mid_start,
                     input int e_err, input int e_fv, input int e_fvec, input int e_ps);
    cut_tbl = tbl;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    for (int k = 1; k <= TOTAL; k++) begin
      @(negedge clk);
      if (k < TOTAL) begin
        chk($sformatf("dut_in@%0d", k), int'(bus.dut_in), k / PER);
        chk($sformatf("busy@%0d", k), int'(bus.busy), 1);
        chk($sformatf("done_early@%0d", k), int'(bus.done), 0);
      end else begin
        chk("done_pulse", int'(bus.done), 1);
        chk("busy_end", int'(bus.busy), 0);
        chk("dut_in_end", int'(bus.dut_in), 0);
      end
      bus.start = (mid_start && k == 6) ? 1'b1 : 1'b0;
    end
    @(negedge clk);
    chk("done_one_cycle", int'(bus.done), 0);
    repeat (3) @(negedge clk);
    chk("err_cnt", int'(bus.err_cnt), e_err);
    chk("fail_valid", int'(bus.fail_valid), e_fv);
    if (e_fv != 0) chk("fail_vec", int'(bus.fail_vec), e_fvec);
    chk("pass", int'(bus.pass), e_ps);
    chk("idle_busy", int'(bus.busy), 0);
  endtask

  vec_t vt[6];
  int   e_err, e_fv, e_fvec, e_ps;
  int   seen_done;
  int   prev_err;

  initial begin
    vt[0] = '{tbl: 8'h1F, err: 0, fv: 0, fvec: 0, ps: 1};
    vt[1] = '{tbl: 8'h00, err: 5, fv: 1, fvec: 0, ps: 0};
    vt[2] = '{tbl: 8'hFF, err: 3, fv: 1, fvec: 5, ps: 0};
    vt[3] = '{tbl: 8'h1E, err: 1, fv: 1, fvec: 0, ps: 0};
    vt[4] = '{tbl: 8'h9F, err: 1, fv: 1, fvec: 7, ps: 0};
    vt[5] = '{tbl: 8'h3F, err: 1, fv: 1, fvec: 5, ps: 0};

    bus.start = 1'b0; bus.abort = 1'b0;
    bsat.start = 1'b0; bsat.abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_dut_in", int'(bus.dut_in), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_pass", int'(bus.pass), 0);
    chk("rst_err", int'(bus.err_cnt), 0);
    chk("rst_fv", int'(bus.fail_valid), 0);
    chk("rst_fvec", int'(bus.fail_vec), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      run(vt[i].tbl, (i == 1), vt[i].err, vt[i].fv, vt[i].fvec, vt[i].ps);

    for (int i = 0; i < 20; i++) begin
      logic [7:0] t;
      t = 8'($urandom);
      model(t, 255, e_err, e_fv, e_fvec, e_ps);
      run(t, ($urandom_range(0, 1) == 1), e_err, e_fv, e_fvec, e_ps);
    end

    // abort landing on edge e0+10
    cut_tbl = 8'h00;
    e_err = 0;
    for (int v = 0; (v + 1) * PER <= 9; v++)
      if (cut_tbl[v] != gold(v)) e_err++;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    for (int k = 1; k <= 9; k++) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk); bus.abort = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_dut_in", int'(bus.dut_in), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_pass", int'(bus.pass), 0);
    chk("abort_err", int'(bus.err_cnt), e_err);
    chk("abort_fv", int'(bus.fail_valid), (e_err > 0) ? 1 : 0);
    seen_done = 0;
    for (int k = 0; k < TOTAL + 4; k++) begin
      @(negedge clk);
      if (bus.done) seen_done = 1;
    end
    chk("abort_no_done", seen_done, 0);

    // start and abort together in IDLE: abort wins
    prev_err = int'(bus.err_cnt);
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk); bus.start = 1'b0; bus.abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("start_abort_busy", int'(bus.busy), 0);
    chk("start_abort_err_held", int'(bus.err_cnt), prev_err);

    // saturating counter on the narrow instance
    @(negedge clk); bsat.start = 1'b1;
    @(negedge clk); bsat.start = 1'b0;
    seen_done = 0;
    for (int k = 0; k < TOTAL + 20 && seen_done == 0; k++) begin
      @(negedge clk);
      if (bsat.done) seen_done = 1;
    end
    chk("sat_done_seen", seen_done, 1);
    chk("sat_err", int'(bsat.err_cnt), 3);
    chk("sat_pass", int'(bsat.pass), 0);
    chk("sat_fvec", int'(bsat.fail_vec), 0);

    // asynchronous reset mid-run
    cut_tbl = 8'h00;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", int'(bus.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_dut_in", int'(bus.dut_in), 0);
    chk("arst_err", int'(bus.err_cnt), 0);
    chk("arst_fv", int'(bus.fail_valid), 0);
    chk("arst_fvec", int'(bus.fail_vec), 0);
    chk("arst_pass", int'(bus.pass), 0);
    chk("arst_done", int'(bus.done), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    run(8'h1F, 1'b0, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
